// File: rtl/xmem_regbank.sv
// xmem_regbank: AVR external-memory peripheral register bank.
// Latches the multiplexed AVR address and synchronises the read and write strobes
// into clk. It decodes a 256-byte window holding the motor, encoder, servo, digital
// and version registers. All state changes on posedge clk.
module xmem_regbank #(
    parameter logic [7:0] BASE_HI = 8'h11,
    parameter int         N_MOT   = 6,
    parameter int         N_ENC   = 4,
    parameter int         N_SRV   = 6,
    parameter int         SRV_W   = 10,
    parameter int         SRV_RST = 0,
    parameter logic [7:0] VER_MAJ = 8'h00,
    parameter logic [7:0] VER_MIN = 8'h07
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               ad_in,
    output logic [7:0]               ad_out,
    output logic                     ad_oe,
    input  logic [7:0]               a_hi,
    input  logic                     ale,
    input  logic                     nRD,
    input  logic                     nWR,
    output logic [7:0]               aout,
    output logic                     ramce,
    output logic [2*N_MOT-1:0]       mot_ctl,
    output logic [8*N_MOT-1:0]       mot_vel,
    input  logic [16*N_ENC-1:0]      enc_cnt,
    output logic [SRV_W*N_SRV-1:0]   srv_pos,
    input  logic [7:0]               digital
);

    logic [15:0] addr_reg;
    logic [7:0]  wdat_reg;
    logic        nrd_s1_reg;
    logic        nrd_s2_reg;
    logic        nwr_s1_reg;
    logic        nwr_s2_reg;
    logic [7:0]  rdata_next;

    logic [1:0]       mot_ctl_reg [N_MOT];
    logic [7:0]       mot_vel_reg [N_MOT];
    logic [15:0]      enc_hold_reg [N_ENC];
    logic [7:0]       srv_lo_reg [N_SRV];
    logic [SRV_W-1:0] srv_pos_reg [N_SRV];
    logic [7:0]       srv_hi [N_SRV];

    logic       hit;
    logic [7:0] off;
    logic       wr_commit;
    logic       rd_strobe;

    assign hit   = (addr_reg[15:8] == BASE_HI);
    assign off   = addr_reg[7:0];
    assign aout  = addr_reg[7:0];
    assign ramce = ~addr_reg[15];

    // Write commits on the synchronised rising edge of nWR; reads fire on the falling
    // edge of nRD. A read is blocked while nWR is also low.
    assign wr_commit = hit & nwr_s1_reg & ~nwr_s2_reg;
    assign rd_strobe = hit & ~nrd_s1_reg & nrd_s2_reg & nwr_s1_reg;
    assign ad_oe     = hit & ~nrd_s1_reg & nwr_s1_reg;

    // Address latch: follows the bus while ale is high and holds while it is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= 16'hFFFF;
        end else if (ale) begin
            addr_reg <= {a_hi, ad_in};
        end
    end

    // Two-flop strobe synchronisers. Reset to idle-high so that any edge in flight
    // is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            nrd_s1_reg <= 1'b1;
            nrd_s2_reg <= 1'b1;
            nwr_s1_reg <= 1'b1;
            nwr_s2_reg <= 1'b1;
        end else begin
            nrd_s1_reg <= nRD;
            nrd_s2_reg <= nrd_s1_reg;
            nwr_s1_reg <= nWR;
            nwr_s2_reg <= nwr_s1_reg;
        end
    end

    // Write data tracks the bus while the synchronised nWR is low. The last sample
    // taken is the one that gets committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdat_reg <= 8'h00;
        end else if (!nwr_s1_reg) begin
            wdat_reg <= ad_in;
        end
    end

    // Read data register: loaded once per read access from the decoded register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ad_out <= 8'h00;
        end else if (rd_strobe) begin
            ad_out <= rdata_next;
        end
    end

    genvar gi;

    // Motor channels: ctl at offset 2i (2 bits), velocity at offset 2i+1.
    generate
        for (gi = 0; gi < N_MOT; gi++) begin : g_mot
            localparam logic [7:0] OFF_CTL = 8'(2 * gi);
            localparam logic [7:0] OFF_VEL = 8'(2 * gi + 1);

            // Register the commit for this channel's ctl or velocity byte.
            always_ff @(posedge clk) begin
                if (rst) begin
                    mot_ctl_reg[gi] <= 2'b00;
                    mot_vel_reg[gi] <= 8'h00;
                end else if (wr_commit) begin
                    if (off == OFF_CTL) begin
                        mot_ctl_reg[gi] <= wdat_reg[1:0];
                    end
                    if (off == OFF_VEL) begin
                        mot_vel_reg[gi] <= wdat_reg;
                    end
                end
            end

            assign mot_ctl[2*gi +: 2] = mot_ctl_reg[gi];
            assign mot_vel[8*gi +: 8] = mot_vel_reg[gi];
        end
    endgenerate

    // Encoder channels: reading the low byte snapshots the full count. The high
    // byte is then served from that snapshot, so a 16-bit read stays coherent.
    generate
        for (gi = 0; gi < N_ENC; gi++) begin : g_enc
            localparam logic [7:0] OFF_LO = 8'(8'h20 + 2 * gi);

            // Capture the whole count when its low byte is read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    enc_hold_reg[gi] <= 16'h0000;
                end else if (rd_strobe && off == OFF_LO) begin
                    enc_hold_reg[gi] <= enc_cnt[16*gi +: 16];
                end
            end
        end
    endgenerate

    // Servo channels: the low byte is staged first. Writing the high byte then
    // loads the complete position in a single cycle.
    generate
        for (gi = 0; gi < N_SRV; gi++) begin : g_srv
            localparam logic [7:0] OFF_LO = 8'(8'h40 + 2 * gi);
            localparam logic [7:0] OFF_HI = 8'(8'h40 + 2 * gi + 1);

            // Stage the low byte and commit the full position on a high-byte write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    srv_lo_reg[gi]  <= 8'h00;
                    srv_pos_reg[gi] <= SRV_W'(SRV_RST);
                end else if (wr_commit) begin
                    if (off == OFF_LO) begin
                        srv_lo_reg[gi] <= wdat_reg;
                    end
                    if (off == OFF_HI) begin
                        srv_pos_reg[gi] <= {wdat_reg[SRV_W-9:0], srv_lo_reg[gi]};
                    end
                end
            end

            assign srv_hi[gi] = 8'(srv_pos_reg[gi][SRV_W-1:8]);
            assign srv_pos[SRV_W*gi +: SRV_W] = srv_pos_reg[gi];
        end
    endgenerate

    // Read decode. Offsets that are unmapped or past the channel count read as zero.
    always_comb begin
        rdata_next = 8'h00;
        for (int i = 0; i < N_MOT; i++) begin
            if (off == 8'(2 * i))     rdata_next = {6'b000000, mot_ctl_reg[i]};
            if (off == 8'(2 * i + 1)) rdata_next = mot_vel_reg[i];
        end
        for (int i = 0; i < N_ENC; i++) begin
            if (off == 8'(8'h20 + 2 * i))     rdata_next = enc_cnt[16*i +: 8];
            if (off == 8'(8'h20 + 2 * i + 1)) rdata_next = enc_hold_reg[i][15:8];
        end
        for (int i = 0; i < N_SRV; i++) begin
            if (off == 8'(8'h40 + 2 * i))     rdata_next = srv_lo_reg[i];
            if (off == 8'(8'h40 + 2 * i + 1)) rdata_next = srv_hi[i];
        end
        if (off == 8'h60) rdata_next = digital;
        if (off == 8'hFE) rdata_next = VER_MAJ;
        if (off == 8'hFF) rdata_next = VER_MIN;
    end

endmodule
